// File: rtl/hmvq18_sel.sv
// hmvq18_sel: element-selection stage of the 18-element mismatch-shaping DAC.
// Turns on exactly num_r elements, picking the largest SFM values; ties are
// broken by a rotating priority pointer that advances by the previous count.
module hmvq18_sel #(
    parameter int NEL = 18,
    parameter int CW  = 5,
    parameter int FW  = 7,
    parameter int SCW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [CW-1:0]   code,
    input  logic [FW-1:0]   SFM0,
    input  logic [FW-1:0]   SFM1,
    input  logic [FW-1:0]   SFM2,
    input  logic [FW-1:0]   SFM3,
    input  logic [FW-1:0]   SFM4,
    input  logic [FW-1:0]   SFM5,
    input  logic [FW-1:0]   SFM6,
    input  logic [FW-1:0]   SFM7,
    input  logic [FW-1:0]   SFM8,
    input  logic [FW-1:0]   SFM9,
    input  logic [FW-1:0]   SFM10,
    input  logic [FW-1:0]   SFM11,
    input  logic [FW-1:0]   SFM12,
    input  logic [FW-1:0]   SFM13,
    input  logic [FW-1:0]   SFM14,
    input  logic [FW-1:0]   SFM15,
    input  logic [FW-1:0]   SFM16,
    input  logic [FW-1:0]   SFM17,
    output logic [NEL-1:0]  SV,
    output logic [CW-1:0]   ptr,
    output logic            code_err,
    output logic            sat_flag,
    output logic [SCW-1:0]  sat_cnt
);

    logic [FW-1:0] sfm  [NEL];
    logic [CW-1:0] pos  [NEL];
    logic [CW-1:0] rank [NEL];
    logic [CW-1:0] num_r;
    logic [CW-1:0] num_next;
    logic [CW-1:0] ptr_next;
    logic [CW:0]   ptr_sum;
    logic          any_sat;
    logic          code_bad;

    // Gather the individual filter outputs into an indexable array.
    always_comb begin
        sfm[0]  = SFM0;
        sfm[1]  = SFM1;
        sfm[2]  = SFM2;
        sfm[3]  = SFM3;
        sfm[4]  = SFM4;
        sfm[5]  = SFM5;
        sfm[6]  = SFM6;
        sfm[7]  = SFM7;
        sfm[8]  = SFM8;
        sfm[9]  = SFM9;
        sfm[10] = SFM10;
        sfm[11] = SFM11;
        sfm[12] = SFM12;
        sfm[13] = SFM13;
        sfm[14] = SFM14;
        sfm[15] = SFM15;
        sfm[16] = SFM16;
        sfm[17] = SFM17;
    end

    // Priority position of each element relative to the pointer, (i - ptr) mod NEL.
    // The i < ptr branch may overflow CW bits in the middle, but the final
    // result is in 0..NEL-1 so modular wrap gives the right answer.
    always_comb begin
        for (int unsigned i = 0; i < NEL; i++) begin
            if (CW'(i) >= ptr)
                pos[i] = CW'(i) - ptr;
            else
                pos[i] = CW'(i) + CW'(NEL) - ptr;
        end
    end

    // Rank every element and select those ranked below the requested count.
    always_comb begin
        SV = '0;
        for (int unsigned i = 0; i < NEL; i++) begin
            rank[i] = '0;
            for (int unsigned j = 0; j < NEL; j++) begin
                if ((sfm[j] > sfm[i]) || ((sfm[j] == sfm[i]) && (pos[j] < pos[i])))
                    rank[i] = rank[i] + CW'(1);
            end
            SV[i] = (rank[i] < num_r);
        end
    end

    // Next-state terms: clamped count, wrapped pointer, saturation detect.
    always_comb begin
        code_bad = (code > CW'(NEL));
        num_next = code_bad ? CW'(NEL) : code;
        ptr_sum  = {1'b0, ptr} + {1'b0, num_r};
        if (ptr_sum >= (CW+1)'(NEL))
            ptr_next = CW'(ptr_sum - (CW+1)'(NEL));
        else
            ptr_next = CW'(ptr_sum);
        any_sat = 1'b0;
        for (int unsigned i = 0; i < NEL; i++) begin
            if (sfm[i] == '1)
                any_sat = 1'b1;
        end
    end

    // State registers: reset wins over enable; everything holds when en is low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_r    <= '0;
            ptr      <= '0;
            code_err <= 1'b0;
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (en) begin
            num_r <= num_next;
            ptr   <= ptr_next;
            if (code_bad)
                code_err <= 1'b1;
            if (any_sat) begin
                sat_flag <= 1'b1;
                if (sat_cnt != '1)
                    sat_cnt <= sat_cnt + SCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hmvq18_sel.sv
// tb_hmvq18_sel: directed test-plan scenarios followed by randomized traffic,
// compared against a greedy pick-the-best reference model.
module tb_hmvq18_sel;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [4:0]  code;
    logic [6:0]  sfm [18];
    logic [17:0] SV;
    logic [4:0]  ptr;
    logic        code_err;
    logic        sat_flag;
    logic [15:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_num, m_ptr, m_satc;
    bit m_err, m_satf;

    always #5 clk = ~clk;

    hmvq18_sel #(.NEL(18), .CW(5), .FW(7), .SCW(16)) dut (
        .clk(clk), .rstn(rstn), .en(en), .code(code),
        .SFM0(sfm[0]),   .SFM1(sfm[1]),   .SFM2(sfm[2]),   .SFM3(sfm[3]),
        .SFM4(sfm[4]),   .SFM5(sfm[5]),   .SFM6(sfm[6]),   .SFM7(sfm[7]),
        .SFM8(sfm[8]),   .SFM9(sfm[9]),   .SFM10(sfm[10]), .SFM11(sfm[11]),
        .SFM12(sfm[12]), .SFM13(sfm[13]), .SFM14(sfm[14]), .SFM15(sfm[15]),
        .SFM16(sfm[16]), .SFM17(sfm[17]),
        .SV(SV), .ptr(ptr), .code_err(code_err), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tie-break order: smaller distance from the pointer going upward wins.
    function automatic int prio(input int i);
        return (i - m_ptr + 18) % 18;
    endfunction

    // Pick m_num elements one at a time, each the best of those remaining.
    function automatic logic [17:0] model_sv();
        bit taken [18];
        logic [17:0] r = '0;
        for (int i = 0; i < 18; i++) taken[i] = 0;
        for (int k = 0; k < m_num; k++) begin
            int best = -1;
            for (int i = 0; i < 18; i++) begin
                if (!taken[i]) begin
                    if (best < 0 || sfm[i] > sfm[best] ||
                        (sfm[i] == sfm[best] && prio(i) < prio(best)))
                        best = i;
                end
            end
            taken[best] = 1;
            r[best] = 1'b1;
        end
        return r;
    endfunction

    function automatic int popcount(input logic [17:0] v);
        int c = 0;
        for (int i = 0; i < 18; i++) c += v[i];
        return c;
    endfunction

    // Advance one clock edge and apply the same rules to the model.
    task automatic tick();
        bit sat_seen = 0;
        @(posedge clk);
        for (int i = 0; i < 18; i++) if (sfm[i] == 7'd127) sat_seen = 1;
        if (!rstn) begin
            m_num = 0; m_ptr = 0; m_err = 0; m_satf = 0; m_satc = 0;
        end else if (en) begin
            m_ptr = (m_ptr + m_num) % 18;
            m_num = (code > 18) ? 18 : int'(code);
            if (code > 18) m_err = 1;
            if (sat_seen) begin
                m_satf = 1;
                if (m_satc < 65535) m_satc++;
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sv"},   32'(SV),       32'(model_sv()));
        check({tag, "_pop"},  popcount(SV),  m_num);
        check({tag, "_ptr"},  32'(ptr),      m_ptr);
        check({tag, "_err"},  32'(code_err), 32'(m_err));
        check({tag, "_satf"}, 32'(sat_flag), 32'(m_satf));
        check({tag, "_satc"}, 32'(sat_cnt),  m_satc);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 18; i++) sfm[i] = 7'(v);
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b1;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; code = '0;
        set_all(0);
        m_num = 0; m_ptr = 0; m_err = 0; m_satf = 0; m_satc = 0;

        // reset state
        do_reset();
        check_all("reset");
        check("reset_sv0", 32'(SV), 0);

        // equal values, rotating pointer
        set_all(10); en = 1'b1; code = 5'd5;
        tick(); check_all("rot1"); check("rot1_sv", 32'(SV), 32'h0001F);
        tick(); check_all("rot2"); check("rot2_sv", 32'(SV), 32'h003E0); check("rot2_ptr", 32'(ptr), 5);
        tick(); check_all("rot3"); check("rot3_sv", 32'(SV), 32'h07C00); check("rot3_ptr", 32'(ptr), 10);

        // pointer wrap
        do_reset();
        code = 5'd16; tick();
        code = 5'd4;  tick();
        check_all("wrap1"); check("wrap1_sv", 32'(SV), 32'h30003); check("wrap1_ptr", 32'(ptr), 16);
        tick(); check_all("wrap2"); check("wrap2_ptr", 32'(ptr), 2);

        // distinct values
        do_reset();
        for (int i = 0; i < 18; i++) sfm[i] = 7'(i * 7);
        code = 5'd3;  tick(); check_all("dist3");  check("dist3_sv", 32'(SV), 32'h38000);
        code = 5'd0;  tick(); check_all("dist0");  check("dist0_sv", 32'(SV), 0);
        code = 5'd18; tick(); check_all("dist18"); check("dist18_sv", 32'(SV), 32'h3FFFF);

        // out-of-range code, sticky error
        code = 5'd25; tick(); check_all("oor");  check("oor_sv", 32'(SV), 32'h3FFFF); check("oor_err", 32'(code_err), 1);
        code = 5'd4;  tick(); check_all("oor2"); check("oor2_err", 32'(code_err), 1);
        tick(); check_all("oor3");
        do_reset(); check_all("oor_rst"); check("oor_rst_err", 32'(code_err), 0);

        // saturation count, then hold with en low
        set_all(20); sfm[3] = 7'd127; code = 5'd2;
        for (int k = 0; k < 3; k++) begin tick(); check_all("sat"); end
        check("sat_cnt3", 32'(sat_cnt), 3); check("sat_flag", 32'(sat_flag), 1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            code = 5'(k + 7);
            sfm[k + 5] = 7'(k * 30);
            tick(); check_all("hold");
        end
        check("hold_cnt", 32'(sat_cnt), 3);
        // SV follows SFM combinationally while holding
        sfm[0] = 7'd126; #1; check_all("hold_comb");
        en = 1'b1;

        // reset mid-run
        do_reset();
        code = 5'd7; tick();
        code = 5'd9; tick(); check("pre_ptr", 32'(ptr), 7); check("pre_pop", popcount(SV), 9);
        rstn = 1'b0; tick(); rstn = 1'b1;
        check_all("midrst"); check("midrst_sv", 32'(SV), 0);

        // randomized traffic
        for (int n = 0; n < 10000; n++) begin
            rstn = ($urandom % 300) != 0;
            en   = ($urandom % 5) != 0;
            code = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 18));
            for (int i = 0; i < 18; i++) begin
                case ($urandom % 8)
                    0:       sfm[i] = 7'd127;
                    1, 2:    sfm[i] = 7'($urandom);
                    default: sfm[i] = 7'($urandom_range(0, 3));
                endcase
            end
            tick();
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hmvq18_sel.md
Name: hmvq18_sel

Overview:
- Vector-quantizer / element-selection stage of the 18-element mismatch-shaping DAC.
- Sits directly upstream of the 2nd-order 18-input shaping loop filter, closing its loop:
  - consumes the filter's 18 per-element outputs SFM0..SFM17;
  - takes the modulator's element-count code;
  - drives the 18-bit selection vector SV back into the filter and onward to the unit-element drivers.
- Turns on exactly N elements: those with the largest SFM values, with ties broken by a rotating priority pointer.

Parameters:
- NEL, 18, number of unit elements (fixed at 18 for this build; parameter exists for bench checks only).
- CW, 5, width of count code.
- FW, 7, width of each SFM input.
- SCW, 16, width of saturation event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- en  input  1  sample enable; state advances only when high.
- code  input  5  requested number of active elements, legal 0..18.
- SFM17..SFM0  input  7 each  loop-filter outputs, unsigned.
- SV  output  18  selection vector; bit i=1 turns element i on.
- ptr  output  5  current tie-break priority pointer, 0..17.
- code_err  output  1  sticky: an out-of-range code was seen.
- sat_flag  output  1  sticky: an SFM value hit full scale.
- sat_cnt  output  16  count of enabled cycles with any SFM==127.

Behaviour:

Reset (rstn=0 at a rising edge):
- num_r=0, ptr=0, code_err=0, sat_flag=0, sat_cnt=0.
- SV therefore reads 0 one combinational settle after reset.
- Reset mid-operation discards all state on that edge; there is no partial update.

Count register (on an edge with rstn=1, en=1):
- num_r <= min(code, 18).
- If code>18, code_err <= 1. code_err is sticky until reset.

Pointer update (on the same edge, using the pre-edge num_r):
- ptr <= (ptr + num_r) mod 18.
- Wrap is explicit: a sum of 18..35 subtracts 18.
- ptr never leaves 0..17.

Hold:
- When en=0, num_r, ptr, sat_cnt and the sticky flags all hold.
- SV keeps tracking the current SFM inputs combinationally.

Selection (combinational from SFM*, num_r and ptr; no register on SV):
- Priority position of element i: p_i = (i - ptr) mod 18.
- rank_i = (number of j with SFM_j > SFM_i) + (number of j with SFM_j == SFM_i and p_j < p_i).
- SV[i] = (rank_i < num_r).
- Ranks form a permutation of 0..17, so popcount(SV) == num_r exactly, always.
- Compares are unsigned 7-bit. Ranks are 5-bit sums of 17 compare bits.

Latency:
- code presented before edge k appears as popcount(SV) after edge k (one cycle).
- The downstream filter registers SV. The loop stays one-delay, so the SV path must be purely combinational.

Saturation monitor (on an enabled edge, if any SFM_i == 127):
- sat_flag <= 1 (sticky).
- sat_cnt increments, saturating at 16'hFFFF with no wrap.

Simultaneous events:
- code>18 and saturation on the same edge: both flags set independently.
- Reset has priority over en.

Test Plan:
- Reset, then all SFM=10, en=1, code=5 held → after edge 1: SV=18'h0001F, ptr=0; after edge 2: ptr=5, SV=18'h003E0; after edge 3: ptr=10, SV=18'h07C00.
- Pointer wrap: all SFM equal, ptr preloaded to 16 via prior counts (e.g. code=16 for one edge then 4), num_r=4 → SV=18'h30003; next ptr=(16+4) mod 18=2.
- Distinct values: SFM_i = i*7, code=3, ptr=0 → SV=18'h38000 (elements 17,16,15). With code=0 → SV=0. With code=18 → SV=18'h3FFFF.
- Out-of-range: code=25 → num_r=18, SV=18'h3FFFF, code_err=1. It stays 1 after code returns to 4, until rstn=0 at an edge.
- Saturation and hold: SFM3=127 for 3 enabled cycles → sat_cnt=3, sat_flag=1. Then en=0 for 5 cycles with SFM3=127 → sat_cnt stays 3 and ptr is unchanged.
- Reset mid-run: rstn=0 for one edge while ptr=7, num_r=9 → next cycle ptr=0, SV=0, flags and sat_cnt cleared. For random SFM/code over 10k cycles, assert popcount(SV)==num_r on every cycle.
